// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic tile engine.
package systolic_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

    // Never returns less than 1 so single-row/column builds still get a real index port.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        w,
                                                   input bit                 sat);
        logic signed [63:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (sat && (s > hi)) begin
            s = hi;
        end else if (sat && (s < lo)) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/os_pe.sv
// One output-stationary MAC cell: forwards A right and B down every cycle and
// accumulates locally whenever both incoming operands carry a valid tag.
module os_pe import systolic_pkg::*; #(
    parameter int unsigned A_W      = 8,
    parameter int unsigned W_W      = 8,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic signed [A_W-1:0]   a_in,
    input  logic                    a_tag_in,
    input  logic signed [W_W-1:0]   b_in,
    input  logic                    b_tag_in,
    output logic signed [A_W-1:0]   a_out,
    output logic                    a_tag_out,
    output logic signed [W_W-1:0]   b_out,
    output logic                    b_tag_out,
    output logic signed [ACC_W-1:0] acc
);

    localparam int unsigned P_W = A_W + W_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_d, acc_q;

    always_comb begin
        prod  = P_W'(a_in) * P_W'(b_in);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (a_tag_in && b_tag_in) begin
            acc_d = ACC_W'(sat_add(64'(acc_q), 64'(prod), ACC_W, SATURATE != 0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out     <= '0;
            a_tag_out <= 1'b0;
            b_out     <= '0;
            b_tag_out <= 1'b0;
            acc_q     <= '0;
        end else begin
            a_out     <= a_in;
            a_tag_out <= a_tag_in;
            b_out     <= b_in;
            b_tag_out <= b_tag_in;
            acc_q     <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/systolic_tile_engine.sv
// ROWS x COLS output-stationary GEMM tile: skews edge operands, runs K beats,
// flushes the wavefront, then drains one result row per handshake.
module systolic_tile_engine import systolic_pkg::*; #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned A_W      = 8,
    parameter int unsigned W_W      = 8,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned K_W      = 12,
    parameter int unsigned SATURATE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [K_W-1:0]           k_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*A_W-1:0]      a_data,
    input  logic [COLS*W_W-1:0]      b_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*ACC_W-1:0]    out_data,
    output logic [clog2(ROWS)-1:0]   out_row,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned RW        = clog2(ROWS);
    localparam int unsigned FW        = clog2(ROWS + COLS);
    localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;

    state_e         state_q, state_d;
    logic [K_W-1:0] klen_q, klen_d, beat_q, beat_d;
    logic [FW-1:0]  flush_q, flush_d;
    logic [RW-1:0]  row_q, row_d;
    logic           clr, beat;

    logic signed [A_W-1:0]   a_h  [ROWS][COLS+1];
    logic                    a_th [ROWS][COLS+1];
    logic signed [W_W-1:0]   b_v  [ROWS+1][COLS];
    logic                    b_tv [ROWS+1][COLS];
    logic signed [ACC_W-1:0] acc  [ROWS][COLS];

    assign beat = in_valid && in_ready;

    // Lane r of A enters r cycles late so that beat k meets B beat k at every cell.
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        if (r == 0) begin : g_direct
            assign a_h[r][0]  = a_data[A_W-1:0];
            assign a_th[r][0] = beat;
        end else begin : g_delay
            logic signed [A_W-1:0] d_q [r];
            logic                  t_q [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) begin
                        d_q[i] <= '0;
                        t_q[i] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= a_data[r*A_W +: A_W];
                    t_q[0] <= beat;
                    for (int i = 1; i < r; i++) begin
                        d_q[i] <= d_q[i-1];
                        t_q[i] <= t_q[i-1];
                    end
                end
            end
            assign a_h[r][0]  = d_q[r-1];
            assign a_th[r][0] = t_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        if (c == 0) begin : g_direct
            assign b_v[0][c]  = b_data[W_W-1:0];
            assign b_tv[0][c] = beat;
        end else begin : g_delay
            logic signed [W_W-1:0] d_q [c];
            logic                  t_q [c];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) begin
                        d_q[i] <= '0;
                        t_q[i] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= b_data[c*W_W +: W_W];
                    t_q[0] <= beat;
                    for (int i = 1; i < c; i++) begin
                        d_q[i] <= d_q[i-1];
                        t_q[i] <= t_q[i-1];
                    end
                end
            end
            assign b_v[0][c]  = d_q[c-1];
            assign b_tv[0][c] = t_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            os_pe #(
                .A_W      (A_W),
                .W_W      (W_W),
                .ACC_W    (ACC_W),
                .SATURATE (SATURATE)
            ) u_pe (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (clr),
                .a_in      (a_h[r][c]),
                .a_tag_in  (a_th[r][c]),
                .b_in      (b_v[r][c]),
                .b_tag_in  (b_tv[r][c]),
                .a_out     (a_h[r][c+1]),
                .a_tag_out (a_th[r][c+1]),
                .b_out     (b_v[r+1][c]),
                .b_tag_out (b_tv[r+1][c]),
                .acc       (acc[r][c])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            klen_q  <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        klen_d    = klen_q;
        beat_d    = beat_q;
        flush_d   = flush_q;
        row_d     = row_q;
        clr       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clr     = 1'b1;
                    klen_d  = k_len;
                    beat_d  = '0;
                    flush_d = '0;
                    row_d   = '0;
                    state_d = (k_len == '0) ? StDrain : StLoad;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_d = beat_q + K_W'(1);
                    if (beat_q == klen_q - K_W'(1)) begin
                        flush_d = '0;
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                // Wait for the last skewed beat to reach the far corner cell.
                if (flush_q == FW'(FLUSH_LEN - 1)) begin
                    row_d   = '0;
                    state_d = StDrain;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        done    = 1'b1;
                        row_d   = '0;
                        state_d = StIdle;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_data = '0;
        for (int c = 0; c < COLS; c++) begin
            out_data[c*ACC_W +: ACC_W] = out_valid ? acc[row_q][c] : '0;
        end
    end

    assign out_row = row_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: default array plus two 16-bit accumulator
// copies (saturating and wrapping) driven in lockstep.
module tb_systolic_tile_engine;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int A_W   = 8;
    localparam int W_W   = 8;
    localparam int ACC_W = 24;
    localparam int K_W   = 12;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [K_W-1:0]        k_len = '0;
    logic                  in_valid = 1'b0;
    logic                  out_ready = 1'b0;
    logic [ROWS*A_W-1:0]   a_data = '0;
    logic [COLS*W_W-1:0]   b_data = '0;

    logic                  in_ready, out_valid, busy, done;
    logic [COLS*ACC_W-1:0] out_data;
    logic [1:0]            out_row;
    logic                  in_ready_s, out_valid_s, busy_s, done_s;
    logic [COLS*16-1:0]    out_data_s;
    logic [1:0]            out_row_s;
    logic                  in_ready_w, out_valid_w, busy_w, done_w;
    logic [COLS*16-1:0]    out_data_w;
    logic [1:0]            out_row_w;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int done_cnt = 0;
    int a_mem [64][ROWS];
    int b_mem [64][COLS];

    systolic_tile_engine #(.ROWS(ROWS), .COLS(COLS), .A_W(A_W), .W_W(W_W), .ACC_W(ACC_W),
                           .K_W(K_W), .SATURATE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready), .a_data(a_data), .b_data(b_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .busy(busy), .done(done)
    );

    systolic_tile_engine #(.ROWS(ROWS), .COLS(COLS), .A_W(A_W), .W_W(W_W), .ACC_W(16),
                           .K_W(K_W), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready_s), .a_data(a_data), .b_data(b_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_row(out_row_s), .busy(busy_s),
        .done(done_s)
    );

    systolic_tile_engine #(.ROWS(ROWS), .COLS(COLS), .A_W(A_W), .W_W(W_W), .ACC_W(16),
                           .K_W(K_W), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready_w), .a_data(a_data), .b_data(b_data), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_row(out_row_w), .busy(busy_w),
        .done(done_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result row: plain sum of products, wrapped to the accumulator width.
    function automatic logic [COLS*ACC_W-1:0] model_row(input int r, input int k);
        logic [COLS*ACC_W-1:0] v;
        longint s;
        v = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int i = 0; i < k; i++) s += longint'(a_mem[i][r]) * longint'(b_mem[i][c]);
            v[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        return v;
    endfunction

    task automatic set_t1();
        for (int r = 0; r < ROWS; r++) begin
            a_mem[0][r] = r + 1;
            b_mem[0][r] = 1;
        end
    endtask

    task automatic set_t2();
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ROWS; r++) a_mem[k][r] = (r == k) ? 1 : 0;
            b_mem[k][0] = k + 1;
            b_mem[k][1] = 2 * k;
            b_mem[k][2] = -k;
            b_mem[k][3] = 7;
        end
    endtask

    task automatic drive_beat(input int idx);
        for (int r = 0; r < ROWS; r++) a_data[r*A_W +: A_W] = A_W'(a_mem[idx][r]);
        for (int c = 0; c < COLS; c++) b_data[c*W_W +: W_W] = W_W'(b_mem[idx][c]);
    endtask

    // Called at #1 after a rising edge with the engine idle.
    task automatic do_run(input string name, input int k, input bit bubbles,
                          input bit start_hold, input int stall_row, input bit chk16);
        int beats, guard, first_beat, row, stall_left, d0;
        bit acc, tog, seen;
        d0 = done_cnt;
        start = 1'b1;
        k_len = K_W'(k);
        @(posedge clk); #1;
        start = start_hold;
        beats = 0; guard = 0; tog = 1'b1; first_beat = -1;
        while (beats < k && guard < 1000) begin
            in_valid = bubbles ? tog : 1'b1;
            drive_beat(beats);
            acc = in_valid && in_ready;
            if (acc && first_beat < 0) first_beat = cyc_cnt;
            @(posedge clk); #1;
            if (acc) beats++;
            tog = !tog;
            guard++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check({name, " beats"}, beats, k);
        row = 0; guard = 0; stall_left = 5; seen = 1'b0;
        while (row < ROWS && guard < 400) begin
            out_ready = !(row == stall_row && stall_left > 0);
            #1;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (!bubbles && k > 0)
                        check({name, " latency"}, cyc_cnt - first_beat, k + ROWS + COLS - 1);
                end
                check({name, " row"}, out_row, row);
                check({name, " data"}, out_data, model_row(row, k));
                check({name, " done"}, done, (out_ready && row == ROWS - 1) ? 1 : 0);
                if (chk16 && out_ready) begin
                    check({name, " sat"}, out_data_s, {4{16'h7fff}});
                    check({name, " wrap"}, out_data_w, {4{16'h8000}});
                    check({name, " row16"}, {out_row_s, out_row_w}, {2'(row), 2'(row)});
                end
                if (out_ready) row++;
                else stall_left--;
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        check({name, " rows"}, row, ROWS);
        check({name, " busy after"}, busy, 0);
        check({name, " done count"}, done_cnt - d0, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst ctl", {busy, in_ready, out_valid, done, busy_s, in_ready_s, out_valid_s,
                          done_s, busy_w, in_ready_w, out_valid_w, done_w}, 0);
        check("rst data", {out_data, out_data_s, out_data_w}, 0);
        check("rst row", {out_row, out_row_s, out_row_w}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_t1();
        do_run("t1", 1, 1'b0, 1'b0, -1, 1'b0);

        set_t2();
        do_run("t2", 4, 1'b0, 1'b0, -1, 1'b0);
        check("t2 hand r1", model_row(1, 4), {24'd7, -24'sd1, 24'd2, 24'd2});

        for (int k = 0; k < 64; k++) begin
            for (int r = 0; r < ROWS; r++) a_mem[k][r] = int'($urandom_range(255)) - 128;
            for (int c = 0; c < COLS; c++) b_mem[k][c] = int'($urandom_range(255)) - 128;
        end
        do_run("t2rand", 64, 1'b0, 1'b0, -1, 1'b0);

        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < ROWS; r++) a_mem[k][r] = -128;
            for (int c = 0; c < COLS; c++) b_mem[k][c] = -128;
        end
        do_run("t3", 2, 1'b0, 1'b0, -1, 1'b1);

        set_t2();
        do_run("t4", 4, 1'b1, 1'b0, 1, 1'b0);

        // Abort an 8-beat run just as beat 3 is presented.
        for (int k = 0; k < 8; k++)
            for (int r = 0; r < ROWS; r++) begin
                a_mem[k][r] = k + r;
                b_mem[k][r] = 3 - r;
            end
        begin
            int d0;
            d0 = done_cnt;
            start = 1'b1;
            k_len = K_W'(8);
            @(posedge clk); #1;
            start = 1'b0;
            in_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                drive_beat(k);
                @(posedge clk); #1;
            end
            drive_beat(3);
            check("t5 busy pre", busy, 1);
            rst_n = 1'b0;
            #1;
            check("t5 ctl in reset", {busy, in_ready, out_valid, done}, 0);
            in_valid = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("t5 no done", done_cnt - d0, 0);
        end
        set_t1();
        do_run("t5", 1, 1'b0, 1'b0, -1, 1'b0);

        do_run("t6 k0", 0, 1'b0, 1'b0, -1, 1'b0);
        set_t2();
        do_run("t6 start held", 4, 1'b0, 1'b1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
